reg_scan_sequencer: RTL

REG_SCAN_SEQUENCER -- requirements
Module: reg_scan_sequencer

---
 rtl/reg_scan_sequencer_if.sv | 16 +
 rtl/reg_scan_sequencer.sv | 129 ++++++++++++
 2 files changed

// File: rtl/reg_scan_sequencer_if.sv
// Record channel between the scan sequencer and its consumer.
// The sequencer offers one sampled register per record; the consumer
// accepts it with rec_ready.
interface reg_scan_sequencer_if #(
  parameter int RegAddrBits = 3,
  parameter int DataWidth   = 16
);
  logic                   rec_valid;
  logic                   rec_ready;
  logic [RegAddrBits-1:0] rec_addr;
  logic [DataWidth-1:0]   rec_data;
  logic                   rec_match;

  modport master (output rec_valid, rec_addr, rec_data, rec_match, input rec_ready);
  modport slave  (input rec_valid, rec_addr, rec_data, rec_match, output rec_ready);
endinterface

// File: rtl/reg_scan_sequencer.sv
// Register scan sequencer: steps inr through 0..TotalReg-1, waits
// SettleCycles after each change, samples out_value against exp_value
// and offers the result as a record. Counts accepted mismatches.
module reg_scan_sequencer #(
  parameter int RegAddrBits  = 3,
  parameter int DataWidth    = 16,
  parameter int TotalReg     = 8,
  parameter int SettleCycles = 2,
  parameter int CntBits      = 8
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   start,
  input  logic                   repeat_mode,
  output logic [RegAddrBits-1:0] inr,
  input  logic [DataWidth-1:0]   out_value,
  input  logic [DataWidth-1:0]   exp_value,
  reg_scan_sequencer_if.master   rec,
  output logic                   busy,
  output logic                   done,
  output logic [CntBits-1:0]     err_count
);

  // Counter is at least one bit wide so SettleCycles=1 still elaborates.
  localparam int CntW = (SettleCycles > 1) ? $clog2(SettleCycles) : 1;
  localparam logic [CntW-1:0]        SettleInit = CntW'(SettleCycles - 1);
  localparam logic [RegAddrBits-1:0] LastReg    = RegAddrBits'(TotalReg - 1);
  localparam logic [CntBits-1:0]     ErrMax     = '1;

  typedef enum logic [1:0] {IDLE, SETTLE, OFFER} state_t;

  state_t                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [RegAddrBits-1:0] inr_q, inr_d;
  logic                   valid_q, valid_d;
  logic [RegAddrBits-1:0] addr_q, addr_d;
  logic [DataWidth-1:0]   data_q, data_d;
  logic                   match_q, match_d;
  logic                   done_q, done_d;
  logic [CntBits-1:0]     err_q, err_d;
  logic                   hs;

  assign hs            = valid_q & rec.rec_ready;
  assign inr           = inr_q;
  assign rec.rec_valid = valid_q;
  assign rec.rec_addr  = addr_q;
  assign rec.rec_data  = data_q;
  assign rec.rec_match = match_q;
  assign busy          = (state_q != IDLE);
  assign done          = done_q;
  assign err_count     = err_q;

  // State and datapath registers; reset clears everything without a clock.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      inr_q   <= '0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      match_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      inr_q   <= inr_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      match_q <= match_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic: settle, sample, offer, advance; done is a one-cycle pulse.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    inr_d   = inr_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    match_d = match_q;
    done_d  = 1'b0;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SETTLE;
          cnt_d   = SettleInit;
          inr_d   = '0;
          err_d   = '0;
        end
      end
      SETTLE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          data_d  = out_value;
          match_d = (out_value == exp_value);
          addr_d  = inr_q;
          valid_d = 1'b1;
          state_d = OFFER;
        end
      end
      OFFER: begin
        if (hs) begin
          valid_d = 1'b0;
          cnt_d   = SettleInit;
          if (!match_q && err_q != ErrMax) err_d = err_q + 1'b1;
          if (inr_q == LastReg) begin
            // Sweep wraps; start is not looked at here, only in IDLE.
            inr_d   = '0;
            done_d  = 1'b1;
            state_d = repeat_mode ? SETTLE : IDLE;
          end else begin
            inr_d   = inr_q + 1'b1;
            state_d = SETTLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
